// File: rtl/rat_intr_pkg.sv
// Shared types for the RAT CPU flag/interrupt stage: FSM state, flag pair,
// and the minimum synchronizer depth.
package rat_intr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ISR  = 1'b1
  } state_t;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  localparam int SYNC_MIN = 2;

endpackage

// File: rtl/intr_sync.sv
// SYNC_STAGES-deep synchronizer for the external interrupt line. LEVEL_MODE
// selects whether int_event is the synchronized level or a rising-edge pulse.
module intr_sync
  import rat_intr_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_MIN,
  parameter bit LEVEL_MODE  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic int_event
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], async_in};
    prev_d  = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  // prev_q holds the previous last-stage sample, so the edge pulse lasts one cycle
  always_comb begin
    if (LEVEL_MODE) int_event = chain_q[SYNC_STAGES-1];
    else            int_event = chain_q[SYNC_STAGES-1] & ~prev_q;
  end

endmodule

// File: rtl/intr_flag_ctrl.sv
// Flag and interrupt control for the RAT CPU: C/Z flags with shadow save/restore,
// interrupt enable, and request FSM. Define INTR_LEVEL_EN for level-sensitive pending.
module intr_flag_ctrl
  import rat_intr_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic I_RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic C_IN,
  input  logic Z_IN,
  input  logic FLG_C_LD,
  input  logic FLG_Z_LD,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic FLG_LD_SEL,
  input  logic I_SET,
  input  logic I_CLR,
  input  logic INT_IN,
  input  logic INT_ACK,
  input  logic RETIE,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic I_FLAG,
  output logic INT_REQ,
  output logic IN_ISR
);

`ifdef INTR_LEVEL_EN
  localparam bit LEVEL_MODE = 1'b1;
`else
  localparam bit LEVEL_MODE = 1'b0;
`endif

  state_t state_q, state_d;
  flags_t flags_q, flags_d;
  flags_t shadow_q, shadow_d;
  logic   i_q, i_d;
  logic   pending_q, pending_d;
  logic   int_event;
  logic   ack_take;
  logic   retie_take;

  intr_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .LEVEL_MODE (LEVEL_MODE)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (INT_IN),
    .int_event(int_event)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (INT_ACK && INT_REQ) state_d = ISR;
      ISR:     if (RETIE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    INT_REQ = pending_q & i_q & (state_q == IDLE);
    IN_ISR  = (state_q == ISR);
    C_FLAG  = flags_q.c;
    Z_FLAG  = flags_q.z;
    I_FLAG  = i_q;
  end

  assign ack_take   = (state_q == IDLE) & INT_ACK & INT_REQ;
  assign retie_take = (state_q == ISR) & RETIE;

  // RETIE restores everything and masks any same-cycle flag or enable strobe
  always_comb begin
    flags_d   = flags_q;
    shadow_d  = shadow_q;
    i_d       = i_q;
    pending_d = pending_q;
    if (retie_take) begin
      flags_d = shadow_q;
      i_d     = 1'b1;
    end else begin
      if (FLG_C_CLR)      flags_d.c = 1'b0;
      else if (FLG_C_SET) flags_d.c = 1'b1;
      else if (FLG_C_LD)  flags_d.c = FLG_LD_SEL ? shadow_q.c : C_IN;
      if (FLG_Z_LD)       flags_d.z = FLG_LD_SEL ? shadow_q.z : Z_IN;
      if (ack_take || I_CLR) i_d = 1'b0;
      else if (I_SET)        i_d = 1'b1;
    end
    if (ack_take) shadow_d = flags_q;
`ifdef INTR_LEVEL_EN
    pending_d = int_event;
`else
    if (int_event)     pending_d = 1'b1;
    else if (ack_take) pending_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q   <= '0;
      shadow_q  <= '0;
      i_q       <= I_RESET_VAL;
      pending_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      shadow_q  <= shadow_d;
      i_q       <= i_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_intr_flag_ctrl.sv
// Scoreboard bench for intr_flag_ctrl: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the flag/interrupt rules.
module tb_intr_flag_ctrl;

   localparam int   S     = 2;
   localparam logic I_RST = 1'b0;
`ifdef INTR_LEVEL_EN
   localparam logic LEVEL = 1'b1;
`else
   localparam logic LEVEL = 1'b0;
`endif

   typedef struct packed {
      logic cIn, zIn, cLd, zLd, cSet, cClr, ldSel, iSet, iClr, intIn, intAck, retie;
   } stim_t;

   typedef struct packed {
      logic c, z, i, req, isr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic C_IN, Z_IN, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR, FLG_LD_SEL;
   logic I_SET, I_CLR, INT_IN, INT_ACK, RETIE;
   logic C_FLAG, Z_FLAG, I_FLAG, INT_REQ, IN_ISR;

   always #5 clk = ~clk;

   intr_flag_ctrl #(
      .SYNC_STAGES(S),
      .I_RESET_VAL(I_RST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .C_IN      (C_IN),
      .Z_IN      (Z_IN),
      .FLG_C_LD  (FLG_C_LD),
      .FLG_Z_LD  (FLG_Z_LD),
      .FLG_C_SET (FLG_C_SET),
      .FLG_C_CLR (FLG_C_CLR),
      .FLG_LD_SEL(FLG_LD_SEL),
      .I_SET     (I_SET),
      .I_CLR     (I_CLR),
      .INT_IN    (INT_IN),
      .INT_ACK   (INT_ACK),
      .RETIE     (RETIE),
      .C_FLAG    (C_FLAG),
      .Z_FLAG    (Z_FLAG),
      .I_FLAG    (I_FLAG),
      .INT_REQ   (INT_REQ),
      .IN_ISR    (IN_ISR)
   );

   exp_t sb[$];
   int   nChecks = 0;
   int   nFail   = 0;

   // Reference model state: architectural flags, shadows, enable, pending, in-service,
   // and the history of INT_IN values seen at each clock edge (newest first).
   logic mC, mZ, mShC, mShZ, mI, mPend, mIsr;
   logic hist[$];

   function automatic void modelReset();
      mC = 0; mZ = 0; mShC = 0; mShZ = 0; mI = I_RST; mPend = 0; mIsr = 0;
      hist = {};
      for (int k = 0; k < S + 2; k++) hist.push_back(1'b0);
   endfunction

   task automatic checkOutput(input string name, input logic act, input logic expv);
      nChecks++;
      if (act !== expv) begin
         nFail++;
         $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic setInputs(input stim_t s);
      C_IN = s.cIn; Z_IN = s.zIn; FLG_C_LD = s.cLd; FLG_Z_LD = s.zLd;
      FLG_C_SET = s.cSet; FLG_C_CLR = s.cClr; FLG_LD_SEL = s.ldSel;
      I_SET = s.iSet; I_CLR = s.iClr; INT_IN = s.intIn; INT_ACK = s.intAck; RETIE = s.retie;
   endtask

   // Drive one cycle of inputs and push the state expected after the coming edge.
   task automatic driveStep(input stim_t s);
      logic req, ack, ret, rise, lvl, oldC, oldZ;
      exp_t e;
      setInputs(s);
      hist.push_front(s.intIn);
      void'(hist.pop_back());
      // An INT_IN rise becomes visible to pending S edges after it is sampled.
      rise = hist[S] & ~hist[S+1];
      lvl  = hist[S];
      req  = mPend & mI & ~mIsr;
      ack  = s.intAck & req;
      ret  = s.retie & mIsr;
      oldC = mC; oldZ = mZ;
      if (ret) begin
         mC = mShC; mZ = mShZ; mI = 1'b1; mIsr = 1'b0;
      end else begin
         if (s.cClr)      mC = 1'b0;
         else if (s.cSet) mC = 1'b1;
         else if (s.cLd)  mC = s.ldSel ? mShC : s.cIn;
         if (s.zLd)       mZ = s.ldSel ? mShZ : s.zIn;
         if (s.iClr)      mI = 1'b0;
         else if (s.iSet) mI = 1'b1;
         if (ack) begin
            mShC = oldC; mShZ = oldZ; mI = 1'b0; mIsr = 1'b1;
         end
      end
      if (LEVEL) mPend = lvl;
      else       mPend = rise ? 1'b1 : (ack ? 1'b0 : mPend);
      e.c = mC; e.z = mZ; e.i = mI; e.isr = mIsr;
      e.req = mPend & mI & ~mIsr;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      driveStep(s);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock.
   task automatic midReset();
      #1;
      setInputs('0);
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("async_rst_c", C_FLAG, 1'b0);
      checkOutput("async_rst_z", Z_FLAG, 1'b0);
      checkOutput("async_rst_i", I_FLAG, I_RST);
      checkOutput("async_rst_req", INT_REQ, 1'b0);
      checkOutput("async_rst_isr", IN_ISR, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      driveStep('0);
   endtask

   // Monitor: compare every output against the scoreboard just after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("sb_c_flag", C_FLAG, e.c);
            checkOutput("sb_z_flag", Z_FLAG, e.z);
            checkOutput("sb_i_flag", I_FLAG, e.i);
            checkOutput("sb_int_req", INT_REQ, e.req);
            checkOutput("sb_in_isr", IN_ISR, e.isr);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      stim_t s;
      logic  lvlIn;
      setInputs('0);
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("rst_c", C_FLAG, 1'b0);
      checkOutput("rst_z", Z_FLAG, 1'b0);
      checkOutput("rst_i", I_FLAG, I_RST);
      checkOutput("rst_req", INT_REQ, 1'b0);
      checkOutput("rst_isr", IN_ISR, 1'b0);
      rst = 1'b0;
      driveStep('0);

      s = '0; s.cIn = 1; s.cLd = 1; s.cClr = 1;
      applyStimulus(s); settle();
      checkOutput("prio_clr_over_ld", C_FLAG, 1'b0);
      s = '0; s.cSet = 1;
      applyStimulus(s); settle();
      checkOutput("prio_set", C_FLAG, 1'b1);

      s = '0; s.iSet = 1;
      applyStimulus(s); settle();
      checkOutput("sei", I_FLAG, 1'b1);
      s = '0; s.intIn = 1;
      applyStimulus(s); settle();
      checkOutput("latency_c1", INT_REQ, 1'b0);
      s = '0;
      applyStimulus(s); settle();
      checkOutput("latency_c2", INT_REQ, 1'b0);
      applyStimulus(s); settle();
      checkOutput("latency_c3", INT_REQ, 1'b1);

      s = '0; s.intAck = 1;
      applyStimulus(s); settle();
      checkOutput("ack_isr", IN_ISR, 1'b1);
      checkOutput("ack_i", I_FLAG, 1'b0);
      checkOutput("ack_req", INT_REQ, 1'b0);

      s = '0; s.cLd = 1; s.zLd = 1; s.zIn = 1;
      applyStimulus(s); settle();
      checkOutput("isr_load_c", C_FLAG, 1'b0);
      checkOutput("isr_load_z", Z_FLAG, 1'b1);

      s = '0; s.intIn = 1;
      applyStimulus(s);
      s = '0;
      repeat (4) applyStimulus(s);
      settle();
      checkOutput("nested_held", INT_REQ, 1'b0);

      s = '0; s.retie = 1; s.cSet = 1; s.iClr = 1;
      applyStimulus(s); settle();
      checkOutput("retie_c", C_FLAG, 1'b1);
      checkOutput("retie_z", Z_FLAG, 1'b0);
      checkOutput("retie_i", I_FLAG, 1'b1);
      checkOutput("retie_isr", IN_ISR, 1'b0);
      checkOutput("nested_req", INT_REQ, ~LEVEL);

      s = '0; s.cSet = 1; s.zLd = 1; s.zIn = 1; s.iSet = 1;
      applyStimulus(s);
      s = '0; s.intIn = 1;
      applyStimulus(s);
      s = '0;
      repeat (3) applyStimulus(s);
      s = '0; s.intAck = 1;
      applyStimulus(s);
      s = '0; s.cLd = 1; s.zLd = 1;
      applyStimulus(s);
      s = '0; s.cLd = 1; s.zLd = 1; s.ldSel = 1;
      applyStimulus(s); settle();
      checkOutput("ldsel_c", C_FLAG, 1'b1);
      checkOutput("ldsel_z", Z_FLAG, 1'b1);
      checkOutput("ldsel_in_isr", IN_ISR, 1'b1);

      midReset();

      s = '0; s.iClr = 1;
      applyStimulus(s);
      s = '0; s.intIn = 1;
      applyStimulus(s);
      s = '0;
      repeat (10) applyStimulus(s);
      settle();
      checkOutput("masked_req", INT_REQ, 1'b0);
      s = '0; s.iSet = 1;
      applyStimulus(s); settle();
      checkOutput("unmask_req", INT_REQ, ~LEVEL);
      s = '0; s.intAck = 1;
      applyStimulus(s);
      s = '0; s.retie = 1;
      applyStimulus(s);

      lvlIn = 1'b0;
      for (int k = 0; k < 1500; k++) begin
         s = '0;
         if ($urandom_range(5) == 0) lvlIn = ~lvlIn;
         s.intIn  = lvlIn;
         s.cIn    = 1'($urandom_range(1));
         s.zIn    = 1'($urandom_range(1));
         s.cLd    = ($urandom_range(3) == 0);
         s.zLd    = ($urandom_range(3) == 0);
         s.cSet   = ($urandom_range(7) == 0);
         s.cClr   = ($urandom_range(7) == 0);
         s.ldSel  = ($urandom_range(3) == 0);
         s.iSet   = ($urandom_range(5) == 0);
         s.iClr   = ($urandom_range(9) == 0);
         s.intAck = ($urandom_range(3) == 0);
         s.retie  = ($urandom_range(7) == 0);
         applyStimulus(s);
      end
      applyStimulus('0);
      settle();
      checkOutput("sb_drained", (sb.size() == 0), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
